// File: rtl/tamarisc_pkg.sv
// -----------------------------------------------------------------------------
// tamarisc_pkg
// Types and constants shared by the tamarisc front end.
//   XLEN          : architectural address/instruction width
//   NOP_INSTR     : canonical no-op (addi x0,x0,0), used as the content of
//                   never-written fetch buffer slots
//   fetch_entry_t : one buffered fetch, {pc, instr}
//   ifetch_state_e: fetch request FSM states
// -----------------------------------------------------------------------------
package tamarisc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifetch_state_e;

endpackage : tamarisc_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched instructions for decode.
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   push_i, data_i : write request and entry
//   pop_i          : read request (ignored when empty)
//   flush_i        : drop all entries; overrides push/pop in the same cycle
//   data_o         : head entry (meaningful only when !empty_o)
//   full_o, empty_o: occupancy flags
//   count_o        : number of valid entries, 0..DEPTH
// Push into a full FIFO is accepted only when a pop frees a slot that cycle.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int unsigned DEPTH     = 2,
    parameter type         entry_t   = logic [63:0],
    parameter entry_t      RESET_VAL = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  entry_t                 data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule : fetch_fifo

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch
// Instruction fetch stage between the PC stage and decode. Issues one word
// request at a time on the instruction-memory port, tags each returned word
// with the PC it was fetched for, and buffers it for decode.
// Ports:
//   clk_i, rst_n_i    : clock, synchronous active-low reset
//   pc_i              : current PC from the PC stage
//   branch_taken_i    : redirect; PC stage holds the target from next cycle
//   incr_pc_o         : PC advance strobe, high on an accepted fetch only
//   imem_req_o        : request, held until imem_gnt_i
//   imem_addr_o       : word-aligned pc_i
//   imem_gnt_i        : request accepted this cycle
//   imem_rvalid_i     : read data valid (at least one cycle after grant)
//   imem_rdata_i      : read data
//   instr_valid_o     : buffer head valid
//   instr_o           : head instruction (0 when the buffer is empty)
//   instr_pc_o        : head instruction's PC (0 when the buffer is empty)
//   instr_ready_i     : decode consumes the head this cycle
//   state_o           : current FSM state, for observation
//
// Handshake: the memory request completes in the cycle imem_req_o and
// imem_gnt_i are both high; the response is the single imem_rvalid_i pulse
// that follows. Decode takes the head in any cycle where instr_valid_o and
// instr_ready_i are both high.
// -----------------------------------------------------------------------------
module ifetch
    import tamarisc_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = tamarisc_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            branch_taken_i,
    output logic            incr_pc_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i,
    output ifetch_state_e   state_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam fetch_entry_t EMPTY_SLOT = '{pc: '0, instr: NOP_INSTR};

    ifetch_state_e   state_q, state_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after;
    logic [CW:0]     credit;
    logic            fifo_full;
    logic            fifo_empty;
    logic            gnt_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // ------------------------------------------------------------------
    // Fetch buffer
    // ------------------------------------------------------------------
    assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};

    fetch_fifo #(
        .DEPTH     (DEPTH),
        .entry_t   (fetch_entry_t),
        .RESET_VAL (EMPTY_SLOT)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (branch_taken_i),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // ------------------------------------------------------------------
    // Occupancy bookkeeping
    // ------------------------------------------------------------------
    assign gnt_fire = (state_q == REQ) && imem_gnt_i;
    assign rsp_fire = (state_q == WAIT) && imem_rvalid_i;

    // A response coinciding with a flush is dropped directly.
    assign push = rsp_fire && !discard_q && !branch_taken_i;
    assign pop  = !fifo_empty && instr_ready_i;

    // The outstanding request already owns a slot, so it counts as occupied.
    assign credit = {1'b0, count} + {{CW{1'b0}}, (state_q == WAIT)};

    // Occupancy as it will be after this cycle's push/pop/flush.
    always_comb begin
        count_after = count;
        if (branch_taken_i) begin
            count_after = '0;
        end else if (push && !pop) begin
            count_after = count + CW'(1);
        end else if (!push && pop) begin
            count_after = count - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            req_pc_q  <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            req_pc_q  <= req_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        req_pc_d  = req_pc_q;

        unique case (state_q)
            IDLE: begin
                if ((credit < (CW+1)'(DEPTH)) && !branch_taken_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_gnt_i) begin
                    req_pc_d = pc_i;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = (count_after < CW'(DEPTH)) ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Only one request can be outstanding, so one bit is enough to mark
        // its response as stale after a redirect.
        if (rsp_fire) begin
            discard_d = 1'b0;
        end else if (branch_taken_i && ((state_q == WAIT) || gnt_fire)) begin
            discard_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_o    = (state_q == REQ);
        incr_pc_o     = gnt_fire && !branch_taken_i;
        imem_addr_o   = {pc_i[XLEN-1:2], 2'b00};
        instr_valid_o = !fifo_empty;
        instr_o       = fifo_empty ? '0 : head.instr;
        instr_pc_o    = fifo_empty ? '0 : head.pc;
        state_o       = state_q;
    end

    // The credit rule reserves a slot before every request.
    a_no_push_full : assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        !(push && fifo_full && !pop)
    );

endmodule : ifetch
